// File: rtl/fir_ch_scheduler.sv
// Two-channel round-robin job scheduler in front of a single FIR core.
// Latches the winning job's configuration, pulses the core start and supervises completion.
module fir_ch_scheduler #(
   parameter int unsigned TIMEOUT_CYC = 1048575,
   parameter int unsigned BUSY_WAIT   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   input  logic [11:0] req_ile_wsp,
   input  logic [27:0] req_ile_probek,
   input  logic [29:0] req_ile_razy,
   output logic [1:0]  req_ready,
   output logic [1:0]  ch_done,
   output logic [1:0]  ch_err,
   output logic [5:0]  fir_ile_wsp,
   output logic [13:0] fir_ile_probek,
   output logic [14:0] fir_ile_razy,
   output logic        fir_start,
   output logic        fir_sel,
   input  logic        fir_pracuje,
   input  logic        fir_done,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_BUSY,
      S_RUN,
      S_DONE,
      S_ERR
   } state_t;

   localparam int CNT_W = 20;
   localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W+1)'(TIMEOUT_CYC);
   localparam logic [CNT_W:0] BUSY_LIM    = (CNT_W+1)'(BUSY_WAIT);
   localparam logic           WD_EN       = (TIMEOUT_CYC != 0);

   state_t           state_q;
   logic [1:0]       req_ready_q;
   logic [1:0]       ch_done_q;
   logic [1:0]       ch_err_q;
   logic [5:0]       wsp_q;
   logic [13:0]      probek_q;
   logic [14:0]      razy_q;
   logic             start_q;
   logic             sel_q;
   logic             busy_q;
   logic             rr_last_q;
   logic [CNT_W-1:0] wd_q;
   logic [CNT_W-1:0] bw_q;

   logic             gnt_any;
   logic             gnt_ch;
   logic             gnt_ok;
   logic [5:0]       gnt_wsp;
   logic [13:0]      gnt_probek;
   logic [14:0]      gnt_razy;
   logic [CNT_W-1:0] wd_d;
   logic [CNT_W-1:0] bw_d;
   logic             wd_expire;
   logic             bw_expire;

   function automatic logic [1:0] ch_bit(input logic ch);
      return ch ? 2'b10 : 2'b01;
   endfunction

   // A core still reporting pracuje is never handed a new job.
   always_comb begin
      gnt_any = (req_valid != 2'b00) && !fir_pracuje;
      case (req_valid)
         2'b01:   gnt_ch = 1'b0;
         2'b10:   gnt_ch = 1'b1;
         2'b11:   gnt_ch = ~rr_last_q;
         default: gnt_ch = 1'b0;
      endcase
      gnt_wsp    = gnt_ch ? req_ile_wsp[11:6]     : req_ile_wsp[5:0];
      gnt_probek = gnt_ch ? req_ile_probek[27:14] : req_ile_probek[13:0];
      gnt_razy   = gnt_ch ? req_ile_razy[29:15]   : req_ile_razy[14:0];
      gnt_ok     = (gnt_wsp != 6'd0) && (gnt_razy != 15'd0);
   end

   // Counters hold the number of cycles elapsed since fir_start; expiry looks one cycle
   // ahead so the error pulse lands exactly TIMEOUT_CYC / BUSY_WAIT cycles after the start.
   always_comb begin
      wd_d      = (&wd_q) ? wd_q : wd_q + CNT_W'(1);
      bw_d      = (&bw_q) ? bw_q : bw_q + CNT_W'(1);
      wd_expire = WD_EN && (({1'b0, wd_q} + (CNT_W+1)'(1)) >= TIMEOUT_LIM);
      bw_expire = ({1'b0, bw_q} + (CNT_W+1)'(1)) >= BUSY_LIM;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         req_ready_q <= 2'b00;
         ch_done_q   <= 2'b00;
         ch_err_q    <= 2'b00;
         wsp_q       <= '0;
         probek_q    <= '0;
         razy_q      <= '0;
         start_q     <= 1'b0;
         sel_q       <= 1'b0;
         busy_q      <= 1'b0;
         rr_last_q   <= 1'b1;
         wd_q        <= '0;
         bw_q        <= '0;
      end else begin
         req_ready_q <= 2'b00;
         ch_done_q   <= 2'b00;
         ch_err_q    <= 2'b00;
         start_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (gnt_any) begin
                  wsp_q       <= gnt_wsp;
                  probek_q    <= gnt_probek;
                  razy_q      <= gnt_razy;
                  sel_q       <= gnt_ch;
                  rr_last_q   <= gnt_ch;
                  wd_q        <= '0;
                  bw_q        <= '0;
                  busy_q      <= 1'b1;
                  req_ready_q <= ch_bit(gnt_ch);
                  if (gnt_ok) begin
                     start_q <= 1'b1;
                     state_q <= S_START;
                  end else begin
                     ch_err_q <= ch_bit(gnt_ch);
                     state_q  <= S_ERR;
                  end
               end
            end
            S_START: begin
               wd_q    <= wd_d;
               bw_q    <= bw_d;
               state_q <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               wd_q <= wd_d;
               bw_q <= bw_d;
               if (fir_done) begin
                  ch_done_q <= ch_bit(sel_q);
                  state_q   <= S_DONE;
               end else if (fir_pracuje) begin
                  state_q <= S_RUN;
               end else if (bw_expire) begin
                  ch_err_q <= ch_bit(sel_q);
                  state_q  <= S_ERR;
               end
            end
            S_RUN: begin
               wd_q <= wd_d;
               if (fir_done) begin
                  ch_done_q <= ch_bit(sel_q);
                  state_q   <= S_DONE;
               end else if (wd_expire) begin
                  ch_err_q <= ch_bit(sel_q);
                  state_q  <= S_ERR;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            S_ERR: begin
               if (!fir_pracuje) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready      = req_ready_q;
   assign ch_done        = ch_done_q;
   assign ch_err         = ch_err_q;
   assign fir_ile_wsp    = wsp_q;
   assign fir_ile_probek = probek_q;
   assign fir_ile_razy   = razy_q;
   assign fir_start      = start_q;
   assign fir_sel        = sel_q;
   assign busy           = busy_q;

endmodule
